// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-add 32x32->64 multiplier sequencer driving a shared ALU
module alu_mult_sequencer #(
    parameter int          WIDTH  = 32,
    parameter logic [3:0]  ADD_OP = 4'b0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] MultA,
    input  logic [WIDTH-1:0] MultB,
    input  logic [WIDTH-1:0] AluOut,
    output logic [3:0]       AluOperation,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;
    logic             carry;
    logic             accept;

    assign AluOperation = ADD_OP;
    assign AluA         = Hi;
    assign AluB         = ((state == S_RUN) && Lo[0]) ? mcand : '0;

    // The shared ALU has no carry-out; recover it from the operand and sum MSBs.
    assign carry = (AluA[WIDTH-1] & AluB[WIDTH-1]) |
                   ((AluA[WIDTH-1] | AluB[WIDTH-1]) & ~AluOut[WIDTH-1]);

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            Hi    <= '0;
            Lo    <= '0;
            mcand <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (accept) begin
            state <= S_RUN;
            mcand <= MultA;
            Lo    <= MultB;
            Hi    <= '0;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    Hi    <= {carry, AluOut[WIDTH-1:1]};
                    Lo    <= {AluOut[0], Lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// tb/tb_alu_mult_sequencer.sv - self-checking bench for alu_mult_sequencer
module tb_alu_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] MultA, MultB, AluOut, AluA, AluB, Hi, Lo;
    logic [3:0]  AluOperation;
    logic        busy, done;

    int tests = 0;
    int fails = 0;
    int ndone = 0;

    always #5 clk = ~clk;

    alu_mult_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .MultA(MultA), .MultB(MultB),
        .AluOut(AluOut), .AluOperation(AluOperation), .AluA(AluA), .AluB(AluB),
        .busy(busy), .done(done), .Hi(Hi), .Lo(Lo)
    );

    // Shared ALU stand-in: only add is meaningful to the sequencer.
    assign AluOut = (AluOperation == 4'b0010) ? AluA + AluB : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=running 2=done. After i iterations the
    // {Hi,Lo} pair holds the partial product A*B[i-1:0] above the unconsumed B bits.
    int          m_phase = 0;
    int          m_i = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_reg = '0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        logic [63:0] p;
        m_valid = 1;
        if (reset) begin
            m_phase = 0; m_i = 0; m_a = '0; m_b = '0; m_reg = '0;
        end else if (start && m_phase != 1) begin
            m_phase = 1; m_i = 0; m_a = MultA; m_b = MultB;
            m_reg = {32'd0, MultB};
        end else if (m_phase == 1) begin
            m_i++;
            p = 64'(m_a) * (64'(m_b) & ((64'd1 << m_i) - 64'd1));
            m_reg = (p << (32 - m_i)) | (64'(m_b) >> m_i);
            if (m_i == 32) m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 64'(busy), 64'(m_phase == 1));
            chk("done", 64'(done), 64'(m_phase == 2));
            chk("aluop", 64'(AluOperation), 64'h2);
            chk("alua", 64'(AluA), 64'(m_reg[63:32]));
            chk("alub", 64'(AluB), (m_phase == 1 && m_b[m_i]) ? 64'(m_a) : 64'd0);
            chk("hi", 64'(Hi), 64'(m_reg[63:32]));
            chk("lo", 64'(Lo), 64'(m_reg[31:0]));
            if (done) ndone++;
        end
    end

    // Starts an operation from IDLE or DONE; returns at the negedge inside the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int ign_at,
                          output int lat, output int bcyc);
        bit got;
        got = 0; lat = -1; bcyc = 0;
        start = 1'b1; MultA = a; MultB = b;
        @(negedge clk);
        start = 1'b0; MultA = $urandom; MultB = $urandom;
        for (int k = 0; k < 40 && !got; k++) begin
            if (done) begin
                got = 1; lat = k;
            end else begin
                if (busy) bcyc++;
                if (ign_at > 0 && k == ign_at) begin
                    start = 1'b1; MultA = $urandom; MultB = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, bcyc, n0;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; MultA = '0; MultB = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd6, 32'd7, 0, lat, bcyc);
        chk("lat_6x7", 64'(lat), 64'd32);
        chk("busy_6x7", 64'(bcyc), 64'd32);
        chk("prod_6x7", {Hi, Lo}, 64'd42);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bcyc);
        chk("prod_ffxff", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'd2, 0, lat, bcyc);
        chk("prod_msb", {Hi, Lo}, 64'h0000_0001_0000_0000);
        run_op(32'h1234_5678, 32'd0, 0, lat, bcyc);
        chk("prod_zero", {Hi, Lo}, 64'd0);
        @(negedge clk);

        n0 = ndone;
        run_op(32'd3, 32'd5, 10, lat, bcyc);
        chk("prod_ign", {Hi, Lo}, 64'd15);
        chk("lat_ign", 64'(lat), 64'd32);
        @(negedge clk); #1;
        chk("single_done", 64'(ndone - n0), 64'd1);

        run_op(32'd6, 32'd7, 0, lat, bcyc);
        chk("b2b_first", 64'(Lo), 64'd42);
        run_op(32'd10, 32'd10, 0, lat, bcyc);
        chk("b2b_lat", 64'(lat), 64'd32);
        chk("b2b_busy", 64'(bcyc), 64'd32);
        chk("b2b_prod", {Hi, Lo}, 64'd100);
        @(negedge clk);

        start = 1'b1; MultA = 32'hFFFF; MultB = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        #1 n0 = ndone;
        repeat (40) @(negedge clk);
        #1 chk("abort_nodone", 64'(ndone - n0), 64'd0);
        run_op(32'd6, 32'd7, 0, lat, bcyc);
        chk("post_abort", {Hi, Lo}, 64'd42);

        for (int t = 0; t < 24; t++) begin
            a = $urandom; b = $urandom;
            if (t % 4 == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(a, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0, lat, bcyc);
            chk("rand_prod", {Hi, Lo}, 64'(a) * 64'(b));
            chk("rand_lat", 64'(lat), 64'd32);
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
